// File: rtl/fmad_resq.sv
// fmad_resq: show-ahead result queue behind an fmad unit.
// It captures each rising edge of fmadDone into a power-of-two ring buffer.
// It tracks one in-flight issue so the upstream knows when a slot is reserved.
// The head entry is presented at full width and signed-saturated to WIDTH bits.
module fmad_resq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       fmadDone,
  input  logic [2*WIDTH-1:0]         fmadOut,
  output logic                       issueOk,
  output logic                       resValid,
  input  logic                       resReady,
  output logic [2*WIDTH-1:0]         resData,
  output logic [WIDTH-1:0]           resNarrow,
  output logic                       resSat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]    headQ;
  logic [PtrW-1:0]    tailQ;
  logic [CntW-1:0]    countQ;
  logic               overflowQ;
  logic               inFlightQ;
  logic               doneQ;

  logic               capture;
  logic               pop;
  logic               full;
  logic               push;
  logic               drop;
  logic [2*WIDTH-1:0] headData;
  logic               inRange;

  assign capture = fmadDone & ~doneQ;
  assign full    = (countQ == Full);
  assign pop     = resValid & resReady;
  // A pop in the same cycle frees the slot, so a capture at full still lands.
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  assign resValid = (countQ != '0);
  assign count    = countQ;
  assign overflow = overflowQ;
  assign issueOk  = ~inFlightQ & ~full;
  assign headData = mem[headQ];
  assign resData  = headData;

  // Control state: pointers, occupancy, sticky overflow, in-flight and done history.
  always_ff @(posedge clock) begin
    if (reset) begin
      headQ     <= '0;
      tailQ     <= '0;
      countQ    <= '0;
      overflowQ <= 1'b0;
      inFlightQ <= 1'b0;
      // Treat done as already high so a level held across reset is not captured.
      doneQ     <= 1'b1;
    end else begin
      doneQ <= fmadDone;
      if (push) tailQ <= tailQ + 1'b1;
      if (pop)  headQ <= headQ + 1'b1;
      if (push && !pop) begin
        countQ <= countQ + 1'b1;
      end else if (!push && pop) begin
        countQ <= countQ - 1'b1;
      end
      if (drop) overflowQ <= 1'b1;
      // Set has priority over the clear from a same-cycle capture.
      if (start) begin
        inFlightQ <= 1'b1;
      end else if (capture) begin
        inFlightQ <= 1'b0;
      end
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem[tailQ] <= fmadOut;
  end

  // The head fits WIDTH bits exactly when its top WIDTH+1 bits are all equal.
  assign inRange = (&headData[2*WIDTH-1:WIDTH-1]) | ~(|headData[2*WIDTH-1:WIDTH-1]);

  // Signed saturation of the head, forced to zero while the queue is empty.
  always_comb begin
    resNarrow = '0;
    resSat    = 1'b0;
    if (resValid) begin
      if (inRange) begin
        resNarrow = headData[WIDTH-1:0];
      end else begin
        resSat    = 1'b1;
        resNarrow = headData[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

endmodule

// File: tb/tb_fmad_resq.sv
// Testbench for fmad_resq (WIDTH=8, DEPTH=4): a table of per-cycle vectors
// plus hand-written sequences for reset, full push/pop and empty push/pop.
module tb_fmad_resq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        fmadDone;
  logic [15:0] fmadOut;
  logic        issueOk;
  logic        resValid;
  logic        resReady;
  logic [15:0] resData;
  logic [7:0]  resNarrow;
  logic        resSat;
  logic [2:0]  count;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        st;
    logic        dn;
    logic [15:0] out;
    logic        rdy;
    logic        v;
    logic [15:0] data;
    logic [7:0]  nar;
    logic        sat;
    logic [2:0]  cnt;
    logic        iok;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  fmad_resq #(.WIDTH(8), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .fmadDone  (fmadDone),
    .fmadOut   (fmadOut),
    .issueOk   (issueOk),
    .resValid  (resValid),
    .resReady  (resReady),
    .resData   (resData),
    .resNarrow (resNarrow),
    .resSat    (resSat),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chkOuts(input string tag, input logic v, input logic [15:0] data,
                         input logic [7:0] nar, input logic sat, input logic [2:0] cnt,
                         input logic iok, input logic ovf);
    chk({tag, ".resValid"}, 32'(resValid), 32'(v));
    if (v) chk({tag, ".resData"}, 32'(resData), 32'(data));
    chk({tag, ".resNarrow"}, 32'(resNarrow), 32'(nar));
    chk({tag, ".resSat"}, 32'(resSat), 32'(sat));
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".issueOk"}, 32'(issueOk), 32'(iok));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic addv(input logic st, input logic dn, input logic [15:0] out, input logic rdy,
                      input logic v, input logic [15:0] data, input logic [7:0] nar,
                      input logic sat, input logic [2:0] cnt, input logic iok, input logic ovf);
    vec_t e;
    e.st = st; e.dn = dn; e.out = out; e.rdy = rdy;
    e.v = v; e.data = data; e.nar = nar; e.sat = sat; e.cnt = cnt; e.iok = iok; e.ovf = ovf;
    vecs.push_back(e);
  endtask

  // One clean capture: done rises for a cycle, then falls.
  task automatic pushVal(input logic [15:0] val);
    fmadDone = 1'b1;
    fmadOut  = val;
    step();
    fmadDone = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //    st dn out      rdy | v  data     nar    sat cnt iok ovf
    addv(1, 0, 16'h0000, 0,   0, 16'h0000, 8'h00, 0, 0, 0, 0);
    addv(0, 1, 16'h0064, 0,   1, 16'h0064, 8'h64, 0, 1, 1, 0);
    addv(0, 0, 16'h0000, 1,   0, 16'h0000, 8'h00, 0, 0, 1, 0);
    addv(1, 0, 16'h0000, 0,   0, 16'h0000, 8'h00, 0, 0, 0, 0);
    addv(0, 1, 16'h0190, 0,   1, 16'h0190, 8'h7F, 1, 1, 1, 0);
    addv(1, 0, 16'h0000, 1,   0, 16'h0000, 8'h00, 0, 0, 0, 0);
    addv(0, 1, 16'hFE70, 0,   1, 16'hFE70, 8'h80, 1, 1, 1, 0);
    addv(1, 0, 16'h0000, 1,   0, 16'h0000, 8'h00, 0, 0, 0, 0);
    addv(0, 1, 16'hFF80, 0,   1, 16'hFF80, 8'h80, 0, 1, 1, 0);
    addv(0, 0, 16'h0000, 1,   0, 16'h0000, 8'h00, 0, 0, 1, 0);
    addv(1, 0, 16'h0000, 0,   0, 16'h0000, 8'h00, 0, 0, 0, 0);
    addv(0, 1, 16'h0080, 0,   1, 16'h0080, 8'h7F, 1, 1, 1, 0);
    addv(1, 0, 16'h0000, 1,   0, 16'h0000, 8'h00, 0, 0, 0, 0);
    addv(0, 1, 16'hFF7F, 0,   1, 16'hFF7F, 8'h80, 1, 1, 1, 0);
    addv(1, 0, 16'h0000, 1,   0, 16'h0000, 8'h00, 0, 0, 0, 0);
    addv(0, 1, 16'h007F, 0,   1, 16'h007F, 8'h7F, 0, 1, 1, 0);
    // done held high: no second capture
    addv(0, 1, 16'h1234, 0,   1, 16'h007F, 8'h7F, 0, 1, 1, 0);
    addv(0, 1, 16'h1234, 0,   1, 16'h007F, 8'h7F, 0, 1, 1, 0);
    addv(0, 0, 16'h0000, 1,   0, 16'h0000, 8'h00, 0, 0, 1, 0);
    // fill to four, then drop a fifth
    addv(0, 1, 16'h0011, 0,   1, 16'h0011, 8'h11, 0, 1, 1, 0);
    addv(0, 0, 16'h0000, 0,   1, 16'h0011, 8'h11, 0, 1, 1, 0);
    addv(0, 1, 16'h0022, 0,   1, 16'h0011, 8'h11, 0, 2, 1, 0);
    addv(0, 0, 16'h0000, 0,   1, 16'h0011, 8'h11, 0, 2, 1, 0);
    addv(0, 1, 16'h0033, 0,   1, 16'h0011, 8'h11, 0, 3, 1, 0);
    addv(0, 0, 16'h0000, 0,   1, 16'h0011, 8'h11, 0, 3, 1, 0);
    addv(0, 1, 16'h0044, 0,   1, 16'h0011, 8'h11, 0, 4, 0, 0);
    addv(0, 0, 16'h0000, 0,   1, 16'h0011, 8'h11, 0, 4, 0, 0);
    addv(0, 1, 16'h0055, 0,   1, 16'h0011, 8'h11, 0, 4, 0, 1);
    addv(0, 0, 16'h0000, 1,   1, 16'h0022, 8'h22, 0, 3, 1, 1);
    addv(0, 0, 16'h0000, 1,   1, 16'h0033, 8'h33, 0, 2, 1, 1);
    addv(0, 0, 16'h0000, 1,   1, 16'h0044, 8'h44, 0, 1, 1, 1);
    addv(0, 0, 16'h0000, 1,   0, 16'h0000, 8'h00, 0, 0, 1, 1);

    // Reset with done held high, then release with done still high.
    reset = 1'b1; start = 1'b0; fmadDone = 1'b1; fmadOut = 16'h00AA; resReady = 1'b0;
    step();
    step();
    chkOuts("reset", 0, 16'h0000, 8'h00, 0, 0, 1, 0);
    reset = 1'b0;
    step();
    chkOuts("levelAcrossReset", 0, 16'h0000, 8'h00, 0, 0, 1, 0);
    fmadDone = 1'b0;

    foreach (vecs[i]) begin
      start    = vecs[i].st;
      fmadDone = vecs[i].dn;
      fmadOut  = vecs[i].out;
      resReady = vecs[i].rdy;
      step();
      chkOuts($sformatf("row%0d", i), vecs[i].v, vecs[i].data, vecs[i].nar, vecs[i].sat,
              vecs[i].cnt, vecs[i].iok, vecs[i].ovf);
    end
    start = 1'b0; fmadDone = 1'b0; resReady = 1'b0;

    // Reset mid-queue, with an in-flight issue and a done edge in the reset cycle.
    pushVal(16'h0001);
    pushVal(16'h0002);
    pushVal(16'h0003);
    chkOuts("midQueue", 1, 16'h0001, 8'h01, 0, 3, 1, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("inFlight.issueOk", 32'(issueOk), 32'(0));
    reset = 1'b1; fmadDone = 1'b1; fmadOut = 16'h0099;
    step();
    chkOuts("midReset", 0, 16'h0000, 8'h00, 0, 0, 1, 0);
    reset = 1'b0;
    step();
    chkOuts("postReset1", 0, 16'h0000, 8'h00, 0, 0, 1, 0);
    step();
    chkOuts("postReset2", 0, 16'h0000, 8'h00, 0, 0, 1, 0);
    fmadDone = 1'b0;
    step();

    // Simultaneous push and pop while full.
    pushVal(16'h000A);
    pushVal(16'h000B);
    pushVal(16'h000C);
    pushVal(16'h000D);
    chkOuts("full", 1, 16'h000A, 8'h0A, 0, 4, 0, 0);
    resReady = 1'b1; fmadDone = 1'b1; fmadOut = 16'h0007;
    step();
    fmadDone = 1'b0;
    chkOuts("fullPushPop", 1, 16'h000B, 8'h0B, 0, 4, 0, 0);
    step();
    chkOuts("drain1", 1, 16'h000C, 8'h0C, 0, 3, 1, 0);
    step();
    chkOuts("drain2", 1, 16'h000D, 8'h0D, 0, 2, 1, 0);
    step();
    chkOuts("drain3", 1, 16'h0007, 8'h07, 0, 1, 1, 0);
    step();
    chkOuts("drain4", 0, 16'h0000, 8'h00, 0, 0, 1, 0);

    // Pop request and capture at empty: push proceeds, pop ignored.
    fmadDone = 1'b1; fmadOut = 16'hFFF6;
    step();
    chkOuts("emptyPushPop", 1, 16'hFFF6, 8'hF6, 0, 1, 1, 0);
    step();
    chkOuts("emptyDrain", 0, 16'h0000, 8'h00, 0, 0, 1, 0);
    fmadDone = 1'b0; resReady = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fmad_resq.md
FMAD_RESQ -- requirements
Module: fmad_resq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the fmad operand width; the captured result width is 2*WIDTH.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of result queue entries; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: the same start pulse driven to fmad, observed for in-flight tracking.
REQ-006 The block SHALL have port fmadDone, input, 1 bit: the fmad completion flag.
REQ-007 The block SHALL have port fmadOut, input, 2*WIDTH bits: the fmad signed result.
REQ-008 The block SHALL have port issueOk, output, 1 bit: the upstream may assert start this cycle.
REQ-009 The block SHALL have port resValid, output, 1 bit: the queue head is valid.
REQ-010 The block SHALL have port resReady, input, 1 bit: the consumer accepts the head.
REQ-011 The block SHALL have port resData, output, 2*WIDTH bits: the head result at full width.
REQ-012 The block SHALL have port resNarrow, output, WIDTH bits: the head result signed-saturated to WIDTH bits.
REQ-013 The block SHALL have port resSat, output, 1 bit: saturation was applied to resNarrow.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH+1) bits: the current number of queued entries.
REQ-015 The block SHALL have port overflow, output, 1 bit: a sticky flag indicating a result was dropped.

Function
REQ-016 The block SHALL keep a register doneQ holding the previous-cycle fmadDone, and SHALL define capture as fmadDone=1 and doneQ=0 (rising edge), so capture works whether fmadDone is a pulse or a level held until the next start.
REQ-017 On capture with count<DEPTH, the block SHALL write fmadOut to the tail entry and advance the tail pointer; the pointer wraps modulo DEPTH.
REQ-018 On capture with count==DEPTH and no pop in the same cycle, the block SHALL drop the result, leave the queue unchanged, and set overflow=1 from the next cycle.
REQ-019 overflow SHALL hold until reset.
REQ-020 The queue SHALL be show-ahead: resValid=(count!=0), and resData SHALL equal the head entry combinationally.
REQ-021 A pop SHALL occur when resValid and resReady are both 1 at posedge; the head pointer then advances, wrapping modulo DEPTH.
REQ-022 When a pop and a capture occur in the same cycle, both SHALL take effect and count SHALL be unchanged; this includes the case count==DEPTH, where the push is accepted and overflow is not set.
REQ-023 When a pop and a capture occur at count==0, the pop SHALL be ignored (resValid=0) and the push SHALL proceed.
REQ-024 Latency: a result captured at posedge N SHALL present resValid=1 with that data after posedge N.
REQ-025 The block SHALL maintain a 1-bit inFlight register: set on start=1, cleared on capture; when both occur in the same cycle, set wins.
REQ-026 issueOk SHALL equal ~inFlight AND (count < DEPTH), so that an accepted issue always has a free slot reserved.
REQ-027 When start is asserted while issueOk=0, inFlight SHALL still be set; any resulting overflow is handled per REQ-018.
REQ-028 Saturation: treating the head as a signed 2*WIDTH value v:
  - if v > 2^(WIDTH-1)-1, resNarrow SHALL be 2^(WIDTH-1)-1 and resSat SHALL be 1;
  - if v < -2^(WIDTH-1), resNarrow SHALL be -2^(WIDTH-1) and resSat SHALL be 1;
  - otherwise resNarrow SHALL be v[WIDTH-1:0] and resSat SHALL be 0.
REQ-029 When resValid=0, resNarrow and resSat SHALL be 0, and resData SHALL be don't-care.
REQ-030 The queue SHALL be FIFO ordered with no reordering; count SHALL never exceed DEPTH.

Reset
REQ-031 While reset=1 at posedge, the block SHALL clear head, tail, count, overflow and inFlight to 0.
REQ-032 While reset=1 at posedge, the block SHALL set doneQ to 1, so a fmadDone held high across reset is not captured.
REQ-033 After reset, outputs SHALL be: resValid=0, count=0, overflow=0, issueOk=1, resSat=0, resNarrow=0.
REQ-034 Reset mid-operation SHALL discard all queued and in-flight results; a done edge in the reset cycle SHALL be ignored.
REQ-035 Entry storage need not be reset.

Verification (WIDTH=8, DEPTH=4)
REQ-036 Single result: start, then fmadDone rises with fmadOut=16'h0064 -> the next cycle shows resValid=1, resData=0x0064, resNarrow=0x64, resSat=0, count=1, issueOk=1.
REQ-037 Saturation: fmadOut=16'h0190 (400) -> resNarrow=0x7F, resSat=1; fmadOut=16'hFE70 (-400) -> resNarrow=0x80, resSat=1; fmadOut=16'hFF80 (-128) -> resNarrow=0x80, resSat=0.
REQ-038 Fill/overflow: four captures with resReady=0 -> count=4, issueOk=0; a fifth done edge -> dropped, overflow=1, count=4; then four pops return the values in original order.
REQ-039 Simultaneous push and pop at full: count=4, resReady=1, done edge with 0x0007 -> count stays 4, overflow=0, and 0x0007 is the last entry popped.
REQ-040 Level done: fmadDone held high for 3 cycles -> exactly one capture; with fmadDone=1 across reset deassert -> no capture.
REQ-041 Reset mid-queue: count=3, reset for 1 cycle -> count=0, resValid=0, overflow=0, issueOk=1.
